// File: rtl/fir_serial_mac.sv
// Coefficient-programmable multi-channel FIR built around one shared
// signed multiply-accumulate, with round-half-up and output saturation.
module fir_serial_mac #(
  parameter int W     = 24,
  parameter int CW    = 24,
  parameter int NTAPS = 16,
  parameter int CH    = 2,
  parameter int SHIFT = 22
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH*W-1:0]          in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH*W-1:0]          out_data,
  output logic [CH-1:0]            out_sat,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [CW-1:0]            coef_data,
  output logic                     busy
);

  localparam int TAW = $clog2(NTAPS);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW  = W + CW;
  localparam int AW  = PW + TAW;

  localparam logic signed [CW-1:0] UNITY =
    {{(CW-1){1'b0}}, 1'b1} << SHIFT;
  localparam logic signed [AW-1:0] HALF =
    {{(AW-1){1'b0}}, 1'b1} << (SHIFT-1);
  localparam logic signed [AW-1:0] YMAX =
    {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] YMIN =
    {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND,
    OUT
  } state_e;

  state_e state_q, state_d;

  logic [TAW-1:0]          tap_q;
  logic [CHW-1:0]          ch_q;
  logic signed [W-1:0]     x_q    [CH][NTAPS];
  logic signed [CW-1:0]    coef_q [NTAPS];
  logic signed [AW-1:0]    acc_q;
  logic signed [W-1:0]     res_q  [CH];
  logic [CH-1:0]           rsat_q;

  logic                    accept;
  logic                    last_tap;
  logic                    last_ch;
  logic                    coef_ok;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    sum;
  logic signed [AW-1:0]    rnd;
  logic signed [AW-1:0]    shf;
  logic                    ovf_hi;
  logic                    ovf_lo;
  logic signed [W-1:0]     ysat;

  assign accept   = in_valid && (state_q == IDLE);
  assign last_tap = (tap_q == TAW'(NTAPS-1));
  assign last_ch  = (ch_q == CHW'(CH-1));
  assign coef_ok  = (32'(coef_addr) < NTAPS);

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = MAC;
      end
      MAC: begin
        if (last_tap && last_ch) state_d = ROUND;
      end
      ROUND: begin
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // First tap of each channel restarts the sum instead of adding to it.
  always_comb begin
    prod = coef_q[tap_q] * x_q[ch_q][tap_q];
    if (tap_q == '0) sum = AW'(prod);
    else             sum = acc_q + AW'(prod);
    rnd    = sum + HALF;
    shf    = rnd >>> SHIFT;
    ovf_hi = (shf > YMAX);
    ovf_lo = (shf < YMIN);
    if (ovf_hi)      ysat = YMAX[W-1:0];
    else if (ovf_lo) ysat = YMIN[W-1:0];
    else             ysat = shf[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < NTAPS; k++) x_q[c][k] <= '0;
        res_q[c] <= '0;
      end
      for (int k = 0; k < NTAPS; k++) begin
        coef_q[k] <= (k == 0) ? UNITY : '0;
      end
      acc_q     <= '0;
      tap_q     <= '0;
      ch_q      <= '0;
      rsat_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else begin
      if (state_q == IDLE && coef_we && coef_ok) begin
        coef_q[coef_addr] <= coef_data;
      end
      if (accept) begin
        for (int c = 0; c < CH; c++) begin
          for (int k = NTAPS-1; k > 0; k--) x_q[c][k] <= x_q[c][k-1];
          x_q[c][0] <= in_data[c*W +: W];
        end
        tap_q <= '0;
        ch_q  <= '0;
      end
      if (state_q == MAC) begin
        acc_q <= sum;
        if (last_tap) begin
          tap_q        <= '0;
          res_q[ch_q]  <= ysat;
          rsat_q[ch_q] <= ovf_hi | ovf_lo;
          ch_q         <= last_ch ? '0 : ch_q + CHW'(1);
        end else begin
          tap_q <= tap_q + TAW'(1);
        end
      end
      if (state_q == ROUND) begin
        out_valid <= 1'b1;
        out_sat   <= rsat_q;
        for (int c = 0; c < CH; c++) out_data[c*W +: W] <= res_q[c];
      end
      if (state_q == OUT && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Directed bench for fir_serial_mac: reference model feeds a queue of
// expected frames that is drained as the filter produces output.
module tb_fir_serial_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;
  logic [1:0]  out_sat;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [23:0] coef_data;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    longint d0;
    longint d1;
    longint s0;
    longint s1;
  } exp_t;

  exp_t   q[$];
  longint mx[2][16];
  longint mc[16];

  fir_serial_mac dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint obs,
                       input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 16; k++) mx[c][k] = 0;
    for (int k = 0; k < 16; k++) mc[k] = 0;
    mc[0] = 64'sd1 << 22;
  endtask

  task automatic model_push(input longint a, input longint b);
    exp_t   e;
    longint acc;
    longint y;
    longint s;
    for (int c = 0; c < 2; c++)
      for (int k = 15; k > 0; k--) mx[c][k] = mx[c][k-1];
    mx[0][0] = a;
    mx[1][0] = b;
    for (int c = 0; c < 2; c++) begin
      acc = 0;
      for (int k = 0; k < 16; k++) acc += mc[k] * mx[c][k];
      y = (acc + (64'sd1 << 21)) >>> 22;
      s = 0;
      if (y > 8388607) begin
        y = 8388607;
        s = 1;
      end else if (y < -8388608) begin
        y = -8388608;
        s = 1;
      end
      if (c == 0) begin
        e.d0 = y;
        e.s0 = s;
      end else begin
        e.d1 = y;
        e.s1 = s;
      end
    end
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    q.delete();
  endtask

  task automatic write_coef(input int addr, input longint val);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = 4'(addr);
    coef_data = val[23:0];
    @(negedge clk);
    coef_we = 1'b0;
    mc[addr] = val;
  endtask

  task automatic frame(input longint a, input longint b, input int hold,
                       input bit we_same, input bit we_mid,
                       input int waddr, input longint wdata);
    int          n;
    exp_t        e;
    logic [47:0] held;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_frame", longint'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = {b[23:0], a[23:0]};
    if (we_same) begin
      coef_we   = 1'b1;
      coef_addr = 4'(waddr);
      coef_data = wdata[23:0];
      mc[waddr] = wdata;
    end
    model_push(a, b);
    @(negedge clk);
    in_valid = 1'b0;
    coef_we  = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      if (we_mid && n == 5) begin
        coef_we   = 1'b1;
        coef_addr = 4'(waddr);
        coef_data = wdata[23:0];
      end else begin
        coef_we = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    coef_we = 1'b0;
    check("latency", n, 34);
    if (q.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      e = q.pop_front();
      check("ch0_data", longint'($signed(out_data[23:0])), e.d0);
      check("ch1_data", longint'($signed(out_data[47:24])), e.d1);
      check("ch0_sat", longint'(out_sat[0]), e.s0);
      check("ch1_sat", longint'(out_sat[1]), e.s1);
    end
    held = out_data;
    repeat (hold) begin
      @(negedge clk);
      check("hold_data", longint'(out_data), longint'(held));
      check("hold_in_ready", longint'(in_ready), 0);
      check("hold_valid", longint'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_hs", longint'(in_ready), 1);
    check("valid_after_hs", longint'(out_valid), 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_sat", longint'(out_sat), 0);
    check("rst_busy", longint'(busy), 0);

    // pass-through with default coefficients
    frame(1000, -5, 0, 0, 0, 0, 0);

    // all-unity taps: impulse walks through the whole delay line
    do_reset();
    for (int k = 0; k < 16; k++) write_coef(k, 64'sd1 << 22);
    frame(100, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) frame(0, 0, 0, 0, 0, 0, 0);

    // saturation at both rails
    do_reset();
    write_coef(1, 64'sd1 << 22);
    frame(8388607, 0, 0, 0, 0, 0, 0);
    frame(8388607, 0, 0, 0, 0, 0, 0);
    frame(-8388608, 0, 0, 0, 0, 0, 0);
    frame(-8388608, 0, 0, 0, 0, 0, 0);

    // downstream back-pressure
    frame(12345, -6789, 10, 0, 0, 0, 0);

    // half-scale coefficient exercises round-half-up on both signs
    write_coef(0, 64'sd1 << 21);
    write_coef(1, 0);
    frame(3, -3, 0, 0, 0, 0, 0);
    frame(1, -1, 0, 0, 0, 0, 0);

    // write during MAC is dropped; write with accept is used at once
    do_reset();
    frame(1000, 0, 0, 0, 1, 3, 12345);
    for (int i = 0; i < 3; i++) frame(0, 0, 0, 0, 0, 0, 0);
    frame(200, 0, 0, 1, 0, 0, 64'sd1 << 21);

    // reset in the middle of MAC
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {24'd6000, 24'd5000};
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("busy_in_mac", longint'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_in_ready", longint'(in_ready), 1);
    check("midrst_busy", longint'(busy), 0);
    rst = 1'b0;
    model_reset();
    q.delete();
    frame(777, -3, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
